// File: rtl/formula_n_sqrt_sum_fsm.sv
// Sums isqrt(args[i]) over N_ARGS 32-bit arguments by farming them out to
// N_ISQRT external isqrt units in ceil(N_ARGS/N_ISQRT) issue/wait rounds.
module formula_n_sqrt_sum_fsm #(
  parameter int N_ARGS  = 3,
  parameter int N_ISQRT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   arg_vld,
  input  logic [N_ARGS*32-1:0]   args,
  output logic                   arg_rdy,
  output logic                   res_vld,
  output logic [31:0]            res,
  output logic [N_ISQRT-1:0]     isqrt_x_vld,
  output logic [N_ISQRT*32-1:0]  isqrt_x,
  input  logic [N_ISQRT-1:0]     isqrt_y_vld,
  input  logic [N_ISQRT*16-1:0]  isqrt_y
);

  localparam int ROUNDS = (N_ARGS + N_ISQRT - 1) / N_ISQRT;
  localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam int AW     = N_ARGS * 32;
  localparam int XW     = N_ISQRT * 32;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t             state;
  logic [AW-1:0]      args_q;
  logic [N_ISQRT-1:0] pending;
  logic [RW-1:0]      round;
  logic [31:0]        acc;

  logic [N_ISQRT-1:0] hit;
  logic [N_ISQRT-1:0] pending_next;
  logic [31:0]        acc_next;

  // Units whose argument index r*N_ISQRT+j exists; only the last round can be partial.
  function automatic logic [N_ISQRT-1:0] active_mask(input int r);
    logic [N_ISQRT-1:0] m;
    m = '0;
    for (int j = 0; j < N_ISQRT; j++)
      if (r * N_ISQRT + j < N_ARGS) m[j] = 1'b1;
    return m;
  endfunction

  assign arg_rdy = (state == IDLE);

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    hit          = (state == WAIT) ? (isqrt_y_vld & pending) : '0;
    pending_next = pending & ~hit;
    acc_next     = acc;
    // NOTE: blocking assignments here chain the per-unit adds within one cycle.
    for (int j = 0; j < N_ISQRT; j++)
      if (hit[j]) acc_next = acc_next + {16'd0, isqrt_y[16*j +: 16]};
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  // NOTE: args_q is a pure data holding register loaded on accept, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      res_vld     <= 1'b0;
      res         <= '0;
      isqrt_x_vld <= '0;
      isqrt_x     <= '0;
      pending     <= '0;
      round       <= '0;
      acc         <= '0;
    end else begin
      res_vld     <= 1'b0;
      isqrt_x_vld <= '0;
      case (state)
        IDLE: begin
          if (arg_vld) begin
            // Round 0 operands go out directly; the remainder is kept pre-shifted.
            isqrt_x     <= args[XW-1:0];
            isqrt_x_vld <= active_mask(0);
            args_q      <= args >> XW;
            acc         <= '0;
            round       <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          pending <= isqrt_x_vld;
          state   <= WAIT;
        end
        WAIT: begin
          acc     <= acc_next;
          pending <= pending_next;
          if (pending_next == '0) begin
            if (round == RW'(ROUNDS - 1)) begin
              res     <= acc_next;
              res_vld <= 1'b1;
              state   <= IDLE;
            end else begin
              round       <= round + 1'b1;
              isqrt_x     <= args_q[XW-1:0];
              isqrt_x_vld <= active_mask(int'(round) + 1);
              args_q      <= args_q >> XW;
              state       <= ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
